// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types, byte-enable constants and lane helpers for the memory bus interface
package mips_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } bus_state_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Size code 11 has no meaning of its own and is folded into word.
    function automatic size_t decode_size(input logic [1:0] raw);
        size_t sz;
        case (raw)
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            default: bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enable(input size_t sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = BE_BYTE0 << off;
            SZ_HALF: be = off[1] ? BE_HALF_HI : BE_HALF_LO;
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

    // Replicating the store data onto every lane lets the byte enables alone pick the target bytes.
    function automatic logic [31:0] lane_data(input size_t sz, input logic [31:0] wdata);
        logic [31:0] d;
        case (sz)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_bus_if_load_align.sv
// rtl/mem_bus_if_load_align.sv - load lane selection and zero/sign extension
//
// Ports:
//   readdata  - raw 32-bit bus read data, little-endian lanes
//   offset    - byte offset addr[1:0] of the load
//   size      - access size
//   sign_ext  - sign-extend byte/half results
//   rdata     - right-justified, extended load result
module load_align
    import mips_bus_pkg::*;
(
    input  logic [31:0] readdata,
    input  logic [1:0]  offset,
    input  size_t       size,
    input  logic        sign_ext,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = readdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? readdata[31:16] : readdata[15:0];
        case (size)
            SZ_BYTE: rdata = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: rdata = readdata;
        endcase
    end

endmodule

// File: rtl/mem_bus_if.sv
// rtl/mem_bus_if.sv - request-to-bus bridge: byte enables, wait-state handling, load alignment
//
// Ports:
//   clk, reset                       - clock, asynchronous active-low reset
//   req_valid/req_ready              - request handshake from the control FSM
//   req_write/req_size/req_signed    - access kind
//   req_addr/req_wdata               - byte address and right-justified store data
//   resp_valid/resp_rdata/misaligned - one-cycle completion with formatted data or error
//   address/read/write/writedata/byteenable/waitrequest/readdata - Avalon-style bus master
module mem_bus_if
    import mips_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misaligned,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    bus_state_t  state;
    size_t       size_q;
    logic [1:0]  off_q;
    logic        signed_q;
    logic        write_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] aligned_rdata;
    size_t       req_sz;
    logic        accept;

    assign req_sz = decode_size(req_size);
    // A new request may be taken in RESP as well, giving back-to-back accesses every two cycles.
    assign req_ready = reset && (state != ACCESS);
    assign accept    = req_valid && (state != ACCESS);

    // Strobes decode only from registered state, so reset drops them without a clock edge
    // and waitrequest never reaches them combinationally.
    assign read       = (state == ACCESS) && !write_q;
    assign write      = (state == ACCESS) && write_q;
    assign resp_valid = (state == RESP);
    assign misaligned = (state == RESP) && err_q;
    assign resp_rdata = rdata_q;

    load_align u_load_align (
        .readdata (readdata),
        .offset   (off_q),
        .size     (size_q),
        .sign_ext (signed_q),
        .rdata    (aligned_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            size_q     <= SZ_BYTE;
            off_q      <= 2'b00;
            signed_q   <= 1'b0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            address    <= 32'h0;
            writedata  <= 32'h0;
            byteenable <= BE_NONE;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        size_q   <= req_sz;
                        off_q    <= req_addr[1:0];
                        signed_q <= req_signed;
                        write_q  <= req_write;
                        if (is_misaligned(req_sz, req_addr[1:0])) begin
                            // Rejected without touching the bus; bus fields keep their old values.
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                            state   <= RESP;
                        end else begin
                            err_q      <= 1'b0;
                            address    <= {req_addr[31:2], 2'b00};
                            byteenable <= byte_enable(req_sz, req_addr[1:0]);
                            writedata  <= lane_data(req_sz, req_wdata);
                            state      <= ACCESS;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!waitrequest) begin
                        rdata_q <= write_q ? 32'h0 : aligned_rdata;
                        state   <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_bus_if.md
# mem_bus_if

Memory bus interface for the multicycle bus CPU. Sits directly downstream of the control state machine: it turns the fetch and memory-stage requests (instruction fetch, load, store) into Avalon-style bus transactions and returns formatted read data. It generates byte enables, handles `waitrequest` stalls, and performs load alignment and extension. It also rejects misaligned accesses without touching the bus.

## Interface
- Parameters: none; address and data widths are fixed at 32.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: access request from the control state machine.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_write` in 1: 1 = store, 0 = load or fetch.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_signed` in 1: sign-extend the load result (byte/half only).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: formatted load data; 0 for stores and errors.
- `misaligned` out 1: qualifies `resp_valid`; access was rejected.
- `address` out 32: word-aligned bus address, `{addr[31:2],2'b00}`.
- `read` out 1: bus read strobe.
- `write` out 1: bus write strobe.
- `waitrequest` in 1: slave stall.
- `writedata` out 32: bus write data.
- `byteenable` out 4: bus byte lanes.
- `readdata` in 32: bus read data.

## Operation
- States are IDLE, ACCESS and RESP.
- **IDLE**
  - `req_ready` = 1.
  - On accept, latch addr, size, signed, write and wdata.
  - Aligned request → ACCESS.
  - Misaligned request (half with addr[0]=1; word with addr[1:0]≠0) → RESP with error flag set; no bus strobe is ever asserted.
- **ACCESS**
  - `read` = !write_q, `write` = write_q.
  - `address`, `byteenable` and `writedata` are driven from the latched fields and held constant.
  - Stay in ACCESS while `waitrequest` = 1.
  - When `waitrequest` = 0, sample `readdata` at that edge → RESP.
- **RESP**
  - `resp_valid` = 1 for exactly one cycle; `misaligned` = error flag.
  - `req_ready` = 1, so a request accepted here proceeds exactly as it would from IDLE.
  - With no request present → IDLE.
- Byte lanes are little-endian: lane k = `readdata[8k+7:8k]` ↔ byte offset k.
- **byteenable**
  - byte: `4'b0001 << addr[1:0]`.
  - half: `addr[1] ? 4'b1100 : 4'b0011`.
  - word: `4'b1111`.
- **writedata**
  - byte: `req_wdata[7:0]` replicated ×4.
  - half: `req_wdata[15:0]` replicated ×2.
  - word: unchanged.
- **Load formatting**
  - Select the lane(s) given by addr[1:0].
  - Zero-extend, or sign-extend when `req_signed` = 1.
  - Word loads ignore `req_signed`.
- **Reset values**
  - State IDLE.
  - `read`, `write`, `resp_valid`, `misaligned` = 0.
  - `address`, `writedata`, `resp_rdata` = 0; `byteenable` = 0.
  - `req_ready` = 1 while `reset` is high and state is IDLE.
- **Reset mid-transaction:** strobes drop asynchronously, no `resp_valid` is produced, and the aborted access is discarded.

## Timing
- **Zero-wait access:** accept at edge 0; ACCESS in cycle 1 with the strobe high for 1 cycle; `resp_valid` in cycle 2.
- **Wait states:** N cycles of `waitrequest` extend ACCESS to N+1 cycles; `resp_valid` follows the completing edge by exactly 1 cycle.
- **Misaligned access:** `resp_valid` with `misaligned` one cycle after accept.
- **Throughput:** best-case sustained rate is one access per 2 cycles (accept in RESP).
- Bus outputs are registered, or decoded purely from registered state; no combinational path from `waitrequest` to `read`/`write`/`address`.
- `resp_rdata` is stable only while `resp_valid` = 1.

## Structure
- Package `mips_bus_pkg` holds:
  - `size_t` enum (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
  - `bus_state_t` enum (`IDLE`, `ACCESS`, `RESP`);
  - byte-enable constants.
- One combinational sub-module, `load_align`: (`readdata`, `addr[1:0]`, size, signed) → `resp_rdata`. It is reused later by `lwl`/`lwr`.

## Test plan
- **Word read, zero wait:** addr 0x1000_0004, `readdata` 0xDEADBEEF.
  - `read` high 1 cycle, `address` 0x1000_0004, `byteenable` 1111.
  - `resp_valid` in cycle 2 with `resp_rdata` 0xDEADBEEF.
- **Signed byte load with wait states:** lb at addr 0x0000_0013, `readdata` 0x80AA_BBCC, `waitrequest` high 2 cycles.
  - `read` held 3 cycles; `address` stays 0x0000_0010; `byteenable` 1000.
  - Result 0xFFFF_FF80.
  - Repeat with `req_signed` = 0: result 0x0000_0080.
- **Half store:** sh at addr 0x0000_0022, wdata 0x1234_ABCD, `waitrequest` high 1 cycle.
  - `writedata` 0xABCD_ABCD, `byteenable` 1100, `write` held 2 cycles.
  - `resp_rdata` 0.
- **Misaligned word:** word load at addr 0x0000_0101.
  - `read` and `write` never assert.
  - `resp_valid` = 1 and `misaligned` = 1 one cycle after accept.
- **Reset mid-read:** drop `reset` while in ACCESS with `waitrequest` = 1.
  - `read` falls without waiting for a clock edge.
  - After release: IDLE, `req_ready` = 1, no `resp_valid`.
- **Back-to-back:** issue a second request during RESP.
  - It is accepted there, and ACCESS starts the next cycle.
